// File: rtl/instr_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue_if
// Instruction-memory port of the prefetch queue: a valid/ready request
// channel carrying a word address, and an in-order response channel that
// returns one data word per accepted request.
//   mem_req_valid  : fetch request offered by the queue
//   mem_req_addr   : word address of the offered request
//   mem_req_ready  : memory accepts; request fires on valid && ready
//   mem_resp_valid : response for the oldest unanswered request
//   mem_resp_data  : response word
// Modports: master = fetch queue side, slave = memory side.
// ---------------------------------------------------------------------------
interface instr_fetch_queue_if;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_data
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
// Sequential instruction prefetcher feeding a single-cycle core. Issues word
// fetches ahead of the core, buffers up to DEPTH returned words tagged with
// their address, and presents the head word when its address matches the
// core PC. A PC that differs from the expected next address flushes the
// queue, marks all in-flight responses as stale and restarts fetching at
// the new PC.
// Ports:
//   clk          : clock, rising edge
//   reset        : synchronous, active-low reset
//   instr_addr   : core PC for the current cycle
//   instr_taken  : core consumes instr this cycle (only when instr_valid)
//   instr        : head word when instr_valid, else NOP (32'h0000_0013)
//   instr_valid  : head entry present and tagged with instr_addr
//   mem          : instruction-memory request/response port (master)
// ---------------------------------------------------------------------------
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                instr_addr,
    input  logic                       instr_taken,
    output logic [31:0]                instr,
    output logic                       instr_valid,
    instr_fetch_queue_if.master        mem
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(DEPTH);

    // Queue storage and bookkeeping state
    logic [31:0]      addr_mem_q [DEPTH];
    logic [31:0]      addr_mem_d [DEPTH];
    logic [31:0]      data_mem_q [DEPTH];
    logic [31:0]      data_mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] in_flight_q, in_flight_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [31:0]      fetch_addr_q, fetch_addr_d;
    logic [31:0]      expect_addr_q, expect_addr_d;
    logic [31:0]      push_addr_q, push_addr_d;

    // Per-cycle control decisions
    logic             redirect_s;
    logic             head_hit_s;
    logic             has_room_s;
    logic             req_fire_s;
    logic             resp_drop_s;
    logic             push_s;
    logic             pop_s;

    // Control decode: redirect, head match, request/response/pop events
    always_comb begin
        redirect_s  = reset && (instr_addr != expect_addr_q);
        head_hit_s  = (count_q != {CNT_W{1'b0}}) && (addr_mem_q[rd_ptr_q] == instr_addr);
        // Slots already promised to in-flight requests count as occupied so a
        // returning response always finds room.
        has_room_s  = ({1'b0, count_q} + {1'b0, in_flight_q}) < DEPTH_EXT;
        resp_drop_s = mem.mem_resp_valid && (discard_q != {CNT_W{1'b0}});
        push_s      = mem.mem_resp_valid && (discard_q == {CNT_W{1'b0}});
        pop_s       = reset && head_hit_s && instr_taken;
        req_fire_s  = reset && !redirect_s && has_room_s && mem.mem_req_ready;
    end

    // Output drive: core-facing instruction and memory request
    always_comb begin
        instr_valid       = reset && head_hit_s;
        if (instr_valid) begin
            instr = data_mem_q[rd_ptr_q];
        end else begin
            instr = NOP_WORD;
        end
        mem.mem_req_valid = reset && !redirect_s && has_room_s;
        mem.mem_req_addr  = fetch_addr_q;
    end

    // Next-state computation; a redirect overrides every other update
    always_comb begin
        addr_mem_d    = addr_mem_q;
        data_mem_d    = data_mem_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        in_flight_d   = in_flight_q;
        discard_d     = discard_q;
        fetch_addr_d  = fetch_addr_q;
        expect_addr_d = expect_addr_q;
        push_addr_d   = push_addr_q;

        if (redirect_s) begin
            rd_ptr_d      = {PTR_W{1'b0}};
            wr_ptr_d      = {PTR_W{1'b0}};
            count_d       = {CNT_W{1'b0}};
            fetch_addr_d  = instr_addr;
            expect_addr_d = instr_addr;
            push_addr_d   = instr_addr;
            // A response arriving now answers one in-flight request and is
            // itself dropped; everything still outstanding becomes stale.
            in_flight_d   = in_flight_q - CNT_W'(mem.mem_resp_valid);
            discard_d     = in_flight_q - CNT_W'(mem.mem_resp_valid);
        end else begin
            in_flight_d = in_flight_q + CNT_W'(req_fire_s) - CNT_W'(mem.mem_resp_valid);
            count_d     = count_q + CNT_W'(push_s) - CNT_W'(pop_s);

            if (req_fire_s) begin
                fetch_addr_d = fetch_addr_q + 32'd4;
            end else begin
                fetch_addr_d = fetch_addr_q;
            end

            if (resp_drop_s) begin
                discard_d = discard_q - CNT_W'(1'b1);
            end else begin
                discard_d = discard_q;
            end

            if (push_s) begin
                addr_mem_d[wr_ptr_q] = push_addr_q;
                data_mem_d[wr_ptr_q] = mem.mem_resp_data;
                wr_ptr_d             = wr_ptr_q + PTR_W'(1'b1);
                push_addr_d          = push_addr_q + 32'd4;
            end else begin
                wr_ptr_d    = wr_ptr_q;
                push_addr_d = push_addr_q;
            end

            if (pop_s) begin
                rd_ptr_d      = rd_ptr_q + PTR_W'(1'b1);
                expect_addr_d = expect_addr_q + 32'd4;
            end else begin
                rd_ptr_d      = rd_ptr_q;
                expect_addr_d = expect_addr_q;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                addr_mem_q[i] <= 32'h0000_0000;
                data_mem_q[i] <= 32'h0000_0000;
            end
            rd_ptr_q      <= {PTR_W{1'b0}};
            wr_ptr_q      <= {PTR_W{1'b0}};
            count_q       <= {CNT_W{1'b0}};
            in_flight_q   <= {CNT_W{1'b0}};
            discard_q     <= {CNT_W{1'b0}};
            fetch_addr_q  <= RESET_PC;
            expect_addr_q <= RESET_PC;
            push_addr_q   <= RESET_PC;
        end else begin
            addr_mem_q    <= addr_mem_d;
            data_mem_q    <= data_mem_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            in_flight_q   <= in_flight_d;
            discard_q     <= discard_d;
            fetch_addr_q  <= fetch_addr_d;
            expect_addr_q <= expect_addr_d;
            push_addr_q   <= push_addr_d;
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_queue
// Directed bench for instr_fetch_queue with a small in-order memory model
// (word at address A is {16'hC0DE, A[15:0]}) and a core model that follows
// the fetched stream. Inputs are driven 1 time unit after each rising edge,
// outputs sampled 2 units after it.
// ---------------------------------------------------------------------------
module tb_instr_fetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    logic        clk;
    logic        reset;
    logic [31:0] instr_addr;
    logic        instr_taken;
    logic [31:0] instr;
    logic        instr_valid;

    instr_fetch_queue_if mem_if ();

    instr_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_addr  (instr_addr),
        .instr_taken (instr_taken),
        .instr       (instr),
        .instr_valid (instr_valid),
        .mem         (mem_if)
    );

    // Bench state
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic        rst_drv = 1'b0;
    logic        take_en = 1'b0;
    logic        jump_en = 1'b0;
    int          ready_mode = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] pc = RESET_PC;
    logic        fired;
    logic [31:0] fire_addr;
    logic [31:0] fire_log [$];
    int          take_cnt = 0;
    req_t        pend [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive memory/core inputs, then sample and update models
    task automatic tick();
        req_t r;
        int   lat;
        @(posedge clk);
        #1;
        cyc++;
        reset = rst_drv;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            r = pend.pop_front();
            mem_if.mem_resp_valid = 1'b1;
            mem_if.mem_resp_data  = word_at(r.addr);
        end else begin
            mem_if.mem_resp_valid = 1'b0;
            mem_if.mem_resp_data  = 32'hDEAD_BEEF;
        end
        instr_addr  = pc;
        instr_taken = take_en;
        case (ready_mode)
            0:       mem_if.mem_req_ready = 1'b1;
            1:       mem_if.mem_req_ready = 1'($urandom_range(0, 1));
            default: mem_if.mem_req_ready = 1'b0;
        endcase
        #1;
        fired = mem_if.mem_req_valid && mem_if.mem_req_ready;
        if (fired) begin
            fire_addr = mem_if.mem_req_addr;
            fire_log.push_back(fire_addr);
            lat   = $urandom_range(lat_min, lat_max);
            r.addr = fire_addr;
            r.due  = cyc + lat;
            if (pend.size() != 0 && r.due <= pend[$].due) r.due = pend[$].due + 1;
            pend.push_back(r);
        end
        check_eq("inflight_le_depth", 32'(pend.size() <= DEPTH), 32'd1);
        if (instr_valid && instr_taken) begin
            check_eq("stream_word", instr, word_at(pc));
            take_cnt++;
            if (jump_en && $urandom_range(0, 15) == 0) begin
                pc = 32'($urandom_range(0, 1023)) << 2;
            end else begin
                pc = pc + 32'd4;
            end
        end
    endtask

    // Hold reset low for n cycles, checking idle outputs, then arm release
    task automatic do_reset(input int n);
        rst_drv = 1'b0;
        take_en = 1'b0;
        jump_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            check_eq("rst_req_valid", 32'(mem_if.mem_req_valid), 32'd0);
            check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
            check_eq("rst_instr_nop", instr, NOP_WORD);
        end
        pend.delete();
        fire_log.delete();
        pc      = RESET_PC;
        rst_drv = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset                 = 1'b0;
        instr_addr            = RESET_PC;
        instr_taken           = 1'b0;
        mem_if.mem_req_ready  = 1'b1;
        mem_if.mem_resp_valid = 1'b0;
        mem_if.mem_resp_data  = 32'h0000_0000;

        // Reset release, L = 1, core takes every cycle
        ready_mode = 0; lat_min = 1; lat_max = 1;
        do_reset(3);
        take_en = 1'b1;
        tick();
        check_eq("t1_req0_fire", 32'(fired), 32'd1);
        check_eq("t1_req0_addr", fire_addr, 32'h0000_0000);
        check_eq("t1_valid_c0", 32'(instr_valid), 32'd0);
        tick();
        check_eq("t1_req1_addr", fire_addr, 32'h0000_0004);
        check_eq("t1_valid_c1", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("t1_steady_valid", 32'(instr_valid), 32'd1);
        end
        check_eq("t1_pc_after_8", pc, 32'h0000_0020);

        // Core never takes: exactly DEPTH requests, then one take frees one slot
        do_reset(2);
        for (int i = 0; i < 10; i++) tick();
        check_eq("t2_fire_cnt", 32'(fire_log.size()), 32'd4);
        for (int i = 0; i < fire_log.size() && i < 4; i++) begin
            check_eq("t2_fire_addr", fire_log[i], 32'(i * 4));
        end
        check_eq("t2_full_req_valid", 32'(mem_if.mem_req_valid), 32'd0);
        check_eq("t2_head_valid", 32'(instr_valid), 32'd1);
        check_eq("t2_head_word", instr, 32'hC0DE_0000);
        fire_log.delete();
        take_en = 1'b1;
        tick();
        take_en = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check_eq("t2_refill_cnt", 32'(fire_log.size()), 32'd1);
        if (fire_log.size() != 0) check_eq("t2_refill_addr", fire_log[0], 32'h0000_0010);

        // Redirect with 3 requests in flight (L = 5)
        lat_min = 5; lat_max = 5;
        do_reset(2);
        tick(); tick(); tick();
        pc = 32'h0000_0100;
        tick();
        check_eq("t3_redir_req_valid", 32'(mem_if.mem_req_valid), 32'd0);
        check_eq("t3_redir_instr_valid", 32'(instr_valid), 32'd0);
        tick();
        check_eq("t3_new_fire", 32'(fired), 32'd1);
        check_eq("t3_new_addr", fire_addr, 32'h0000_0100);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("t3_stale_hidden", 32'(instr_valid), 32'd0);
        end
        tick();
        check_eq("t3_first_valid", 32'(instr_valid), 32'd1);
        check_eq("t3_first_word", instr, 32'hC0DE_0100);

        // Redirect in the same cycle a response arrives, in_flight = 2 (L = 2)
        lat_min = 2; lat_max = 2;
        do_reset(2);
        tick(); tick();
        pc = 32'h0000_0200;
        tick();
        check_eq("t4_resp_present", 32'(mem_if.mem_resp_valid), 32'd1);
        check_eq("t4_redir_req_valid", 32'(mem_if.mem_req_valid), 32'd0);
        tick();
        check_eq("t4_new_addr", fire_addr, 32'h0000_0200);
        tick();
        check_eq("t4_hidden_a", 32'(instr_valid), 32'd0);
        tick();
        check_eq("t4_hidden_b", 32'(instr_valid), 32'd0);
        tick();
        check_eq("t4_first_valid", 32'(instr_valid), 32'd1);
        check_eq("t4_first_word", instr, 32'hC0DE_0200);

        // Random ready, random latency 1..5, occasional jumps
        lat_min = 1; lat_max = 5;
        do_reset(2);
        ready_mode = 1;
        take_en    = 1'b1;
        jump_en    = 1'b1;
        take_cnt   = 0;
        for (int i = 0; i < 400; i++) tick();
        check_eq("t5_progress", 32'(take_cnt >= 20), 32'd1);

        // Reset mid-stream with the queue full, then restart at RESET_PC
        ready_mode = 0; lat_min = 1; lat_max = 1;
        do_reset(2);
        pc = 32'h0000_0000;
        for (int i = 0; i < 8; i++) tick();
        check_eq("t6_full_req_valid", 32'(mem_if.mem_req_valid), 32'd0);
        do_reset(2);
        tick();
        check_eq("t6_restart_fire", 32'(fired), 32'd1);
        check_eq("t6_restart_addr", fire_addr, RESET_PC);
        check_eq("t6_restart_hidden", 32'(instr_valid), 32'd0);
        tick();
        tick();
        check_eq("t6_restart_valid", 32'(instr_valid), 32'd1);
        check_eq("t6_restart_word", instr, 32'hC0DE_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
